// File: rtl/multi_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : multi_key_debounce
// Purpose  : Debounces NUM_KEYS independent active-low mechanical keys. Each
//            channel has a two-flop synchronizer and a four-state FSM. It
//            reports the debounced level, press and release strobes, a
//            long-press strobe and, optionally, auto-repeat strobes.
// Build    : define KEY_AUTO_REPEAT_EN to include the auto-repeat timer.
//            Without it, repeat_pulse is tied low and no repeat counter exists.
// Ports    : clk           - rising-edge clock
//            n_rst         - asynchronous active-low reset
//            key_in        - raw keys, 0 = pressed
//            key_state     - debounced level per key, 1 = pressed
//            press_pulse   - one-cycle strobe on accepted press
//            release_pulse - one-cycle strobe on accepted release
//            long_pulse    - one-cycle strobe after LONG_CYCLES held
//            repeat_pulse  - one-cycle auto-repeat strobe
//            any_pressed   - OR of key_state
// Revision : 1.0 - initial release
// ============================================================================
module multi_key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_pressed
);

  // The debounce counter tops out at DEBOUNCE_CYCLES-1.
  // The hold counter saturates at LONG_CYCLES.
  localparam int c_db_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_hold_w = $clog2(LONG_CYCLES + 1);

  localparam logic [c_db_w-1:0]   c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_hold_w-1:0] c_long     = c_hold_w'(LONG_CYCLES);
  localparam logic [c_hold_w-1:0] c_long_m2  = c_hold_w'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DB_DOWN = 2'd1,
    ST_HELD    = 2'd2,
    ST_DB_UP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer. It resets to 1, which is the "released" level.
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-cycle debounced level of every channel. It feeds the registered
  // any_pressed so that any_pressed lines up with key_state.
  logic [NUM_KEYS-1:0] w_ks_nxt;

  // --------------------------------------------------------------------------
  // Per-channel debounce FSM
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_db_w-1:0]     r_db_cnt;
    logic [c_db_w-1:0]     w_db_nxt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_hold_w-1:0]   w_hold_nxt;
    logic                  w_s;
    logic                  w_hold_step;
    logic                  w_press;
    logic                  w_release;
    logic                  w_long;
    logic                  w_repeat;
    logic                  r_key_state;
    logic                  r_press;
    logic                  r_release;
    logic                  r_long;
    logic                  r_repeat;

    assign w_s = r_sync2[k];

    // A hold step is a cycle spent in HELD with the key still down. The
    // long-press and repeat timers advance only on these cycles, so both
    // timers are frozen while a release is being debounced.
    assign w_hold_step = (r_state == ST_HELD) && !w_s;

    always_comb begin
      w_state_nxt = r_state;
      w_db_nxt    = r_db_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_s) begin
            w_state_nxt = ST_DB_DOWN;
            w_db_nxt    = '0;
          end
        end
        ST_DB_DOWN: begin
          if (w_s) begin
            w_state_nxt = ST_IDLE;
            w_db_nxt    = '0;
          end else if (r_db_cnt == c_db_last) begin
            w_state_nxt = ST_HELD;
            w_db_nxt    = '0;
            w_hold_nxt  = '0;
            w_press     = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (w_s) begin
            // Leave hold counter untouched: a bounce must not restart it.
            w_state_nxt = ST_DB_UP;
            w_db_nxt    = '0;
          end else if (w_hold_step) begin
            if (r_hold_cnt < c_long) begin
              w_hold_nxt = r_hold_cnt + 1'b1;
            end
            // The strobe fires on the step that brings the count to
            // LONG_CYCLES-1. Saturation means this value is seen only
            // once per press.
            if (r_hold_cnt == c_long_m2) begin
              w_long = 1'b1;
            end
          end
        end
        ST_DB_UP: begin
          if (!w_s) begin
            w_state_nxt = ST_HELD;
            w_db_nxt    = '0;
          end else if (r_db_cnt == c_db_last) begin
            w_state_nxt = ST_IDLE;
            w_db_nxt    = '0;
            w_hold_nxt  = '0;
            w_release   = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int                 c_rep_w    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_long_m1 = c_hold_w'(LONG_CYCLES - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic [c_rep_w-1:0] w_rep_nxt;

    // The repeat timer runs only after the long strobe has fired, which is
    // when the hold count is at LONG_CYCLES-1 or has saturated.
    always_comb begin
      w_rep_nxt = r_rep_cnt;
      w_repeat  = 1'b0;
      if (w_press || w_release) begin
        w_rep_nxt = '0;
      end else if (w_hold_step && (r_hold_cnt >= c_long_m1)) begin
        if (r_rep_cnt == c_rep_last) begin
          w_repeat  = 1'b1;
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= w_rep_nxt;
      end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_state     <= ST_IDLE;
        r_db_cnt    <= '0;
        r_hold_cnt  <= '0;
        r_key_state <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_db_cnt    <= w_db_nxt;
        r_hold_cnt  <= w_hold_nxt;
        r_key_state <= w_ks_nxt[k];
        r_press     <= w_press;
        r_release   <= w_release;
        r_long      <= w_long;
        r_repeat    <= w_repeat;
      end
    end

    assign w_ks_nxt[k]      = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DB_UP);
    assign key_state[k]     = r_key_state;
    assign press_pulse[k]   = r_press;
    assign release_pulse[k] = r_release;
    assign long_pulse[k]    = r_long;
    assign repeat_pulse[k]  = r_repeat;
  end

  logic r_any;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_ks_nxt;
    end
  end

  assign any_pressed = r_any;

endmodule
`default_nettype wire

// File: tb/tb_multi_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_key_debounce
// Purpose  : Self-checking bench for multi_key_debounce (4 keys, debounce 4,
//            long 16, repeat 8). It runs a directed opening sequence followed
//            by randomized key activity with occasional resets. A reference
//            model works from run lengths of the synchronized key level and
//            counts held cycles. It queues one expected output record per
//            clock. A monitor pops each record and compares it with the DUT
//            outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_key_debounce;

  localparam int NK    = 4;
  localparam int DB    = 4;
  localparam int LNG   = 16;
  localparam int RPT   = 8;
  localparam int N_DIR = 100;
  localparam int N_RND = 3000;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_state;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_pulse;
  logic [NK-1:0] repeat_pulse;
  logic          any_pressed;

  multi_key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LNG),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] ks;
    logic [NK-1:0] pp;
    logic [NK-1:0] rp;
    logic [NK-1:0] lp;
    logic [NK-1:0] rpt;
    logic          any;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   active = 1'b0;

  // Reference model state. A key is accepted after DB+1 consecutive
  // synchronized samples at the opposite level. The variable held counts
  // samples that were down while pressed and not following an up-sample.
  logic [NK-1:0] m_s1 = '1;
  logic [NK-1:0] m_s2 = '1;
  logic [NK-1:0] m_lvl = '0;
  int            m_run[NK];
  int            m_held[NK];

  // Predicts the outputs after the coming rising edge, given the inputs that
  // were just driven.
  task automatic model_step(output rec_t e);
    logic s;
    e = '0;
    if (!n_rst) begin
      m_s1  = '1;
      m_s2  = '1;
      m_lvl = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  = 0;
        m_held[k] = 0;
      end
      return;
    end
    for (int k = 0; k < NK; k++) begin
      s       = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = key_in[k];
      if (!m_lvl[k]) begin
        if (!s) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k]  = 1'b1;
            m_run[k]  = 0;
            m_held[k] = 0;
            e.pp[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
      end else begin
        if (s) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = 1'b0;
            m_run[k] = 0;
            e.rp[k]  = 1'b1;
          end
        end else begin
          if (m_run[k] == 0) begin
            m_held[k]++;
            if (m_held[k] == LNG - 1)
              e.lp[k] = 1'b1;
            else if (AUTO_REP && m_held[k] >= LNG - 1 + RPT &&
                     ((m_held[k] - (LNG - 1)) % RPT) == 0)
              e.rpt[k] = 1'b1;
          end
          m_run[k] = 0;
        end
      end
    end
    e.ks  = m_lvl;
    e.any = |m_lvl;
  endtask

  // Monitor: the outputs are registered, so a record is presented every cycle.
  initial begin
    rec_t got;
    rec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        got = {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL no_expectation cycle %0d: got %h, required a queued record", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: got ks=%b pp=%b rp=%b lp=%b rpt=%b any=%b, required ks=%b pp=%b rp=%b lp=%b rpt=%b any=%b",
                     cyc, got.ks, got.pp, got.rp, got.lp, got.rpt, got.any,
                     e.ks, e.pp, e.rp, e.lp, e.rpt, e.any);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rec_t          e;
    int            rem[NK];
    logic [NK-1:0] lv;
    int            rst_hold;
    for (int k = 0; k < NK; k++) begin
      m_run[k]  = 0;
      m_held[k] = 0;
      rem[k]    = int'($urandom_range(1, 20));
    end
    lv       = '1;
    rst_hold = 0;
    n_rst    = 1'b0;
    key_in   = '1;
    repeat (3) @(negedge clk);

    for (int c = 0; c < N_DIR + N_RND; c++) begin
      @(negedge clk);
      if (c < N_DIR) begin
        // Directed scenarios:
        // - key0 is a clean press and is held through a reset pulse.
        // - key1 is a 3-cycle glitch.
        // - key2 is a long hold that produces the long/repeat strobes.
        // - key3 bounces up for 2 cycles, then is released cleanly.
        n_rst     = !((c < 2) || (c >= 60 && c < 62));
        key_in[0] = !(c >= 10 && c < 90);
        key_in[1] = !(c >= 12 && c < 15);
        key_in[2] = !(c >= 20 && c < 75);
        key_in[3] = !((c >= 10 && c < 30) || (c >= 32 && c < 45));
      end else begin
        for (int k = 0; k < NK; k++) begin
          if (rem[k] == 0) begin
            lv[k] = ~lv[k];
            case ($urandom_range(0, 2))
              0:       rem[k] = int'($urandom_range(1, 5));
              1:       rem[k] = int'($urandom_range(6, 14));
              default: rem[k] = int'($urandom_range(15, 60));
            endcase
          end
          rem[k]--;
        end
        key_in = lv;
        if (rst_hold == 0 && $urandom_range(0, 399) == 0)
          rst_hold = int'($urandom_range(1, 3));
        n_rst = (rst_hold == 0);
        if (rst_hold > 0) rst_hold--;
      end
      model_step(e);
      exp_q.push_back(e);
      cyc    = c;
      active = 1'b1;
    end

    @(negedge clk);
    active = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_records: got %0d unconsumed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_key_debounce.md
MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count required to accept an edge (>=1).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, held duration after accepted press that raises long_pulse (> DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period after long press (>=1).
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port n_rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port key_in, input, NUM_KEYS, raw asynchronous keys, active-low (0 = pressed).
REQ-008 SHALL have port key_state, output, NUM_KEYS, debounced level per key, 1 = pressed.
REQ-009 SHALL have port press_pulse, output, NUM_KEYS, one-cycle strobe on accepted press.
REQ-010 SHALL have port release_pulse, output, NUM_KEYS, one-cycle strobe on accepted release.
REQ-011 SHALL have port long_pulse, output, NUM_KEYS, one-cycle strobe when held LONG_CYCLES.
REQ-012 SHALL have port repeat_pulse, output, NUM_KEYS, one-cycle auto-repeat strobe.
REQ-013 SHALL have port any_pressed, output, 1, OR-reduction of key_state.

Function
REQ-014 Each key_in bit SHALL pass a two-flop synchronizer (reset value 1) before any use; all logic below acts on synchronized bit s.
REQ-015 Each channel SHALL run an independent FSM: IDLE, DB_DOWN, HELD, DB_UP; channels share no state.
REQ-016 IDLE: s=0 -> DB_DOWN, debounce counter cleared; else stay.
REQ-017 DB_DOWN: counter increments per cycle while s=0; s=1 -> IDLE, counter cleared; counter reaching DEBOUNCE_CYCLES-1 with s=0 -> HELD.
REQ-018 Entry to HELD from DB_DOWN SHALL assert press_pulse one cycle, set key_state=1, clear hold counter.
REQ-019 Latency from first clk edge sampling key_in=0 (held stable) to press_pulse high SHALL be exactly 2+DEBOUNCE_CYCLES cycles; same latency applies to release.
REQ-020 HELD: hold counter increments, saturating at LONG_CYCLES; long_pulse asserts one cycle when counter reaches LONG_CYCLES-1, at most once per press.
REQ-021 HELD: s=1 -> DB_UP, debounce counter cleared, hold counter frozen.
REQ-022 DB_UP: s=1 stable DEBOUNCE_CYCLES cycles -> IDLE, release_pulse one cycle, key_state=0, hold counter cleared; s=0 before that -> HELD, hold counter resumes, no second press_pulse or long_pulse.
REQ-023 key_state SHALL remain 1 throughout HELD and DB_UP.
REQ-024 press_pulse, release_pulse, long_pulse, repeat_pulse SHALL be mutually exclusive per channel in any cycle.
REQ-025 Counters SHALL be sized by $clog2 of their maximum terminal value and SHALL never wrap.
REQ-026 Simultaneous events on different channels SHALL be reported in the same cycle without interaction.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 n_rst low SHALL asynchronously force all FSMs to IDLE, synchronizers to 1, all counters to 0, all outputs to 0.
REQ-029 Reset mid-press SHALL emit no release_pulse; after release of n_rst, a still-low key SHALL be re-debounced from zero and produce press_pulse after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-030 Macro KEY_AUTO_REPEAT_EN defined: after long_pulse, repeat_pulse SHALL assert one cycle every REPEAT_CYCLES cycles while in HELD; repeat timer pauses in DB_UP and restarts at zero on new press.
REQ-031 Macro KEY_AUTO_REPEAT_EN undefined: repeat_pulse SHALL be constant 0 and no repeat counter logic SHALL be synthesized; all other behaviour unchanged.

Verification (NUM_KEYS=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8)
REQ-032 key_in[0] low at cycle 10, held -> press_pulse[0] at cycle 16, key_state[0]=1 from 16, any_pressed=1.
REQ-033 key_in[1] low 3 cycles then high (glitch) -> no pulses, key_state[1] stays 0.
REQ-034 key_in[2] held low 40 cycles from accept -> long_pulse[2] 15 cycles after press_pulse; with KEY_AUTO_REPEAT_EN repeat_pulse[2] every 8 cycles after; without, repeat_pulse=0.
REQ-035 Held key_in[3] bounces high 2 cycles -> no release_pulse, no new press_pulse; then high 10 cycles -> single release_pulse[3] 6 cycles after rising edge.
REQ-036 key_in[0] held, n_rst pulsed low mid-HELD -> all outputs 0 immediately, no release_pulse, press_pulse[0] 6 cycles after n_rst deasserts.
